// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder and its MMIO block.
package dmem_pkg;

  // Upper address half that routes an access to the MMIO block instead of RAM.
  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFAF;

  // MMIO register byte offsets within the block.
  localparam logic [15:0] OFF_LED       = 16'h0000;
  localparam logic [15:0] OFF_COUNT     = 16'h0004;
  localparam logic [15:0] OFF_CONS_DATA = 16'h0008;
  localparam logic [15:0] OFF_CONS_STAT = 16'h000C;

  // Console status word layout.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  // Which MMIO register an access hits; MMIO_NONE reads 0 and ignores writes.
  typedef enum logic [2:0] {
    MMIO_LED,
    MMIO_COUNT,
    MMIO_CONS_DATA,
    MMIO_CONS_STAT,
    MMIO_NONE
  } mmioReg_e;

  // Address bits [1:0] never participate, so decode works on the word offset.
  function automatic mmioReg_e decodeOffset(input logic [13:0] wordOff);
    mmioReg_e hit;
    hit = MMIO_NONE;
    if (wordOff == OFF_LED[15:2])            hit = MMIO_LED;
    else if (wordOff == OFF_COUNT[15:2])     hit = MMIO_COUNT;
    else if (wordOff == OFF_CONS_DATA[15:2]) hit = MMIO_CONS_DATA;
    else if (wordOff == OFF_CONS_STAT[15:2]) hit = MMIO_CONS_STAT;
    return hit;
  endfunction

  function automatic logic [31:0] packStatus(input logic [7:0] fifoCount,
                                             input logic       overflow,
                                             input logic       empty,
                                             input logic       full);
    logic [31:0] word;
    word = '0;
    word[STAT_COUNT_LSB +: 8] = fifoCount;
    word[STAT_OVF_BIT]        = overflow;
    word[STAT_EMPTY_BIT]      = empty;
    word[STAT_FULL_BIT]       = full;
    return word;
  endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// Synchronous FIFO with a combinational head view; used for the console byte stream.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    fill;
  logic             doPush;
  logic             doPop;

  // A pop frees a slot in the same cycle, so full + push + pop is accepted.
  always_comb begin
    doPop   = pop & ~empty;
    doPush  = push & (~full | doPop);
    dropped = push & ~doPush;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && doPush) mem[wrPtr] <= pushData;
  end

  // Status and head view; head reads 0 when nothing is queued.
  always_comb begin
    empty = (fill == '0);
    full  = (fill == CW'(DEPTH));
    count = fill;
    head  = empty ? '0 : mem[rdPtr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables plus LED / cycle counter / console MMIO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [31:0] addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ramIdx;

  logic                  mmioSel;
  mmioReg_e              mmioReg;
  logic                  mmioAcc;
  logic                  ramWrite;
  logic                  ledWr;
  logic                  countLoad;
  logic                  consPush;
  logic                  ovfClear;
  logic                  consPop;
  logic                  consDropped;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [FIFO_CW-1:0]    fifoCount;
  logic [7:0]            fifoCountByte;
  logic [31:0]           cycleCount;
  logic                  overflow;
  logic [31:0]           mmioRdata;
  logic                  unusedAddr;

  assign unusedAddr = ^addr[1:0];
  assign ramIdx     = addr[ADDR_WIDTH+1:2];

  // Address decode and per-register write strobes.
  always_comb begin
    mmioSel   = (addr[31:16] == MMIO_BASE);
    mmioReg   = decodeOffset(addr[15:2]);
    mmioAcc   = req_en & mmioSel;
    ramWrite  = req_en & ~mmioSel & ~rst;
    ledWr     = mmioAcc & (mmioReg == MMIO_LED);
    countLoad = mmioAcc & (mmioReg == MMIO_COUNT) & (wen == 4'hF);
    consPush  = mmioAcc & (mmioReg == MMIO_CONS_DATA) & wen[0];
    ovfClear  = mmioAcc & (mmioReg == MMIO_CONS_STAT) & wen[0] & wdata[STAT_OVF_BIT];
    consPop   = cons_valid & cons_ready;
  end

  // RAM byte-lane writes; the read mux below sees the pre-edge word (read-before-write).
  always_ff @(posedge clk) begin
    if (ramWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) ram[ramIdx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // LED register: only the low two byte lanes exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (ledWr) begin
      if (wen[0]) led[7:0]  <= wdata[7:0];
      if (wen[1]) led[15:8] <= wdata[15:8];
    end
  end

  // Free-running cycle counter; a full-word write overrides the increment.
  always_ff @(posedge clk) begin
    if (rst)            cycleCount <= '0;
    else if (countLoad) cycleCount <= wdata;
    else                cycleCount <= cycleCount + 32'd1;
  end

  // Sticky overflow flag; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)              overflow <= 1'b0;
    else if (consDropped) overflow <= 1'b1;
    else if (ovfClear)    overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_consFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (consPush),
    .pushData (wdata[7:0]),
    .pop      (consPop),
    .head     (cons_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .dropped  (consDropped)
  );

  assign cons_valid    = ~fifoEmpty;
  assign fifoCountByte = 8'(fifoCount);

  // MMIO read mux; console data and unmapped offsets read as 0.
  always_comb begin
    mmioRdata = '0;
    case (mmioReg)
      MMIO_LED:       mmioRdata = {16'h0, led};
      MMIO_COUNT:     mmioRdata = cycleCount;
      MMIO_CONS_STAT: mmioRdata = packStatus(fifoCountByte, overflow, fifoEmpty, fifoFull);
      default:        mmioRdata = '0;
    endcase
  end

  // Registered read data, refreshed on every access (writes included) and held otherwise.
  always_ff @(posedge clk) begin
    if (rst)         rdata <= '0;
    else if (req_en) rdata <= mmioSel ? mmioRdata : ram[ramIdx];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected read data, monitor pops and compares.
module tb_dmem_responder;

  localparam int          DEPTH = 8;
  localparam logic [15:0] MBASE = 16'hBFAF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_en = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  wen = '0;
  logic [31:0] wdata = '0;
  logic        cons_ready = 1'b0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        cons_valid;
  logic [7:0]  cons_data;

  dmem_responder #(.ADDR_WIDTH(12), .FIFO_DEPTH(DEPTH), .MMIO_BASE(MBASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_en     (req_en),
    .addr       (addr),
    .wen        (wen),
    .wdata      (wdata),
    .rdata      (rdata),
    .led        (led),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] ramM [int];
  logic [15:0] ledM;
  logic [7:0]  fq [$];
  bit          ovfM;
  logic [31:0] cntBase;
  int          cntEdge;
  int          edgeNum = 0;

  logic [31:0] expQ [$];
  int          errors = 0;
  int          checks = 0;
  bit          monOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (a[31:16] == MBASE) begin
      case (a[15:0] & 16'hFFFC)
        16'h0000: v = {16'h0, ledM};
        16'h0004: v = cntBase + 32'(edgeNum - cntEdge);
        16'h000C: v = {16'h0, 8'(fq.size()), 5'b0, ovfM, fq.size() == 0, fq.size() == DEPTH};
        default:  v = '0;
      endcase
    end else if (ramM.exists(int'(a[13:2]))) begin
      v = ramM[int'(a[13:2])];
    end
    return v;
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  function automatic void applyEdge(input logic r, input logic q, input logic [31:0] a,
                                    input logic [3:0] w, input logic [31:0] d, input logic rdy);
    bit          mm;
    logic [15:0] off;
    bit          popNow;
    bit          pushReq;
    bit          room;
    logic [31:0] word;
    if (r) begin
      ledM = '0;
      fq.delete();
      ovfM = 1'b0;
      cntBase = '0;
      cntEdge = edgeNum;
      return;
    end
    mm      = q && (a[31:16] == MBASE);
    off     = a[15:0] & 16'hFFFC;
    popNow  = rdy && (fq.size() > 0);
    pushReq = mm && off == 16'h0008 && w[0];
    room    = (fq.size() < DEPTH) || popNow;
    if (popNow) void'(fq.pop_front());
    if (mm && off == 16'h000C && w[0] && d[2]) ovfM = 1'b0;
    if (pushReq) begin
      if (room) fq.push_back(d[7:0]);
      else      ovfM = 1'b1;
    end
    if (mm && off == 16'h0004 && w == 4'hF) begin
      cntBase = d;
      cntEdge = edgeNum;
    end
    if (mm && off == 16'h0000) begin
      if (w[0]) ledM[7:0]  = d[7:0];
      if (w[1]) ledM[15:8] = d[15:8];
    end
    if (q && !mm) begin
      word = ramM.exists(int'(a[13:2])) ? ramM[int'(a[13:2])] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      ramM[int'(a[13:2])] = word;
    end
  endfunction

  task automatic tick(input logic r, input logic q, input logic [31:0] a,
                      input logic [3:0] w, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rst = r; req_en = q; addr = a; wen = w; wdata = d; cons_ready = rdy;
    if (q && !r) expQ.push_back(refRead(a));
    @(posedge clk);
    edgeNum++;
    applyEdge(r, q, a, w, d, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rdy);
  endtask

  // Monitor: compares registered read data and the console/LED outputs against the model.
  initial begin : monitor
    bit reqHit;
    bit rstHit;
    forever begin
      @(posedge clk);
      reqHit = (req_en === 1'b1) && (rst === 1'b0);
      rstHit = (rst === 1'b1);
      @(negedge clk);
      if (monOn) begin
        if (rstHit) check("reset_rdata", rdata, 32'h0);
        if (reqHit) begin
          if (expQ.size() == 0) check("scoreboard_underflow", 32'h1, 32'h0);
          else check("rdata", rdata, expQ.pop_front());
        end
        check("led", 32'(led), 32'(ledM));
        check("cons_valid", 32'(cons_valid), 32'(fq.size() != 0));
        check("cons_data", 32'(cons_data), (fq.size() != 0) ? 32'(fq[0]) : 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [3:0]  w;
    int          r;
    int          offs [5];
    offs = '{0, 4, 8, 12, 16};

    tick(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    monOn = 1'b1;

    // Initialise the RAM words the bench will read.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b0);
    tick(1'b0, 1'b1, 32'h200, 4'hF, 32'h5, 1'b0);

    // Byte-lane write.
    tick(1'b0, 1'b1, 32'h100, 4'hF, 32'h11223344, 1'b0);
    tick(1'b0, 1'b1, 32'h100, 4'b0010, 32'h0000AA00, 1'b0);
    tick(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0);

    // Read-before-write.
    tick(1'b0, 1'b1, 32'h200, 4'hF, 32'hDEADBEEF, 1'b0);
    tick(1'b0, 1'b1, 32'h200, 4'h0, 32'h0, 1'b0);

    // Counter load and wrap, then a partial write that must not load.
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'hF, 32'hFFFFFFFE, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'b0011, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'h0, 32'h0, 1'b0);

    // Fill past full with the sink stalled, then drain.
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, {MBASE, 16'h0008}, 4'h1, 32'h41 + 32'(i), 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h000C}, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0008}, 4'h0, 32'h0, 1'b0);
    idle(10, 1'b1);

    // Clear overflow, refill, then push into a full FIFO while popping.
    tick(1'b0, 1'b1, {MBASE, 16'h000C}, 4'h1, 32'h4, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, {MBASE, 16'h0008}, 4'h1, 32'h30 + 32'(i), 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0008}, 4'h1, 32'h5A, 1'b1);
    tick(1'b0, 1'b1, {MBASE, 16'h000C}, 4'h0, 32'h0, 1'b0);
    idle(10, 1'b1);

    // Mid-operation reset with an aborted write.
    tick(1'b0, 1'b1, {MBASE, 16'h0000}, 4'h3, 32'h1234BEEF, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0010}, 4'hF, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, {MBASE, 16'h0008}, 4'h1, 32'h60 + 32'(i), 1'b0);
    tick(1'b0, 1'b1, 32'h300, 4'hF, 32'hCAFEF00D, 1'b0);
    tick(1'b1, 1'b1, 32'h300, 4'hF, 32'h0, 1'b1);
    tick(1'b0, 1'b1, {MBASE, 16'h0004}, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h300, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h0000}, 4'h0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, {MBASE, 16'h000C}, 4'h0, 32'h0, 1'b0);

    // Randomised mix of RAM (with aliased upper bits) and MMIO traffic.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        a = {($urandom_range(0, 1) == 1) ? 16'h1234 : 16'h0000, 16'h0100 + 16'(4 * $urandom_range(0, 7))};
        w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        tick(1'b0, 1'b1, a, w, $urandom, 1'($urandom));
      end else if (r < 90) begin
        a = {MBASE, 16'(offs[$urandom_range(0, 4)])};
        w = 4'($urandom);
        tick(1'b0, 1'b1, a, w, $urandom, 1'($urandom));
      end else begin
        tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'($urandom));
      end
    end

    idle(3, 1'b0);
    check("scoreboard_drain", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
